// File: rtl/exidle_mc.sv
// exbus idle/status inserter, multi-channel.
// Data passes through; gaps carry error, interrupt, CTS, AUX and idle words.
module exidle_mc #(
  parameter int DW        = 35,
  parameter int NAUX      = 2,
  parameter int NINT      = 4,
  parameter int OPT_IDLE  = 1,
  parameter int LGIDLE    = 23,
  parameter int LGHOLDOFF = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stb,
  input  logic [DW-1:0]   i_word,
  input  logic            i_last,
  output logic            o_busy,
  input  logic [NAUX-1:0] i_aux,
  input  logic            i_cts,
  input  logic [NINT-1:0] i_int,
  input  logic            i_fifo_err,
  output logic            o_stb,
  output logic [DW-1:0]   o_word,
  output logic            o_last,
  output logic [NINT-1:0] o_pending,
  output logic            o_holdoff,
  input  logic            i_busy
);

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_INT  = 3'b001;
  localparam logic [2:0] C_CTS  = 3'b010;
  localparam logic [2:0] C_ERR  = 3'b011;

  logic                 o_stb_q, o_stb_d;
  logic [DW-1:0]        o_word_q, o_word_d;
  logic                 o_last_q, o_last_d;
  logic                 spec_q, spec_d;
  logic [NINT-1:0]      pend_q, pend_d;
  logic [NINT-1:0]      last_int_q, last_int_d;
  logic                 last_err_q, last_err_d;
  logic [NAUX-1:0]      last_aux_q, last_aux_d;
  logic                 err_flag_q, err_flag_d;
  logic                 cts_flag_q, cts_flag_d;
  logic                 aux_flag_q, aux_flag_d;
  logic [LGHOLDOFF-1:0] holdoff_q, holdoff_d;

  logic            accept, load, acc_spec, acc_any;
  logic            acc_err, acc_int, acc_cts;
  logic [2:0]      code_q;
  logic [NINT-1:0] pend_clr, pend_eff;
  logic            err_eff, cts_eff, aux_eff, hold_clr;
  logic            idle_to;

  assign accept   = o_stb_q && !i_busy;
  assign load     = !o_stb_q || !i_busy;
  assign code_q   = o_word_q[DW-5:DW-7];
  assign acc_spec = accept && spec_q;
  assign acc_any  = accept && (o_word_q[DW-1:DW-2] == 2'b11);
  assign acc_err  = acc_spec && (code_q == C_ERR);
  assign acc_int  = acc_spec && (code_q == C_INT);
  assign acc_cts  = acc_spec && (code_q == C_CTS);

  // Flag views with this cycle's accept already applied, so a word
  // leaving the slot never causes an immediate duplicate.
  assign pend_clr = acc_int ? o_word_q[NINT-1:0] : '0;
  assign pend_eff = pend_q & ~pend_clr;
  assign err_eff  = err_flag_q && !acc_err;
  assign cts_eff  = cts_flag_q && !(acc_cts && i_cts);
  assign aux_eff  = aux_flag_q && !acc_any;
  assign hold_clr = (holdoff_q == '0) && !(acc_err || acc_int);

  generate
    if (OPT_IDLE != 0) begin : g_idle
      logic [LGIDLE-1:0] idle_q, idle_d;

      // Idle counter: runs while the output is empty, saturates.
      always_comb begin
        idle_d = idle_q;
        if (o_stb_q)
          idle_d = '0;
        else if (idle_q != '1)
          idle_d = idle_q + LGIDLE'(1);
      end

      // Idle counter register.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) idle_q <= '0;
        else         idle_q <= idle_d;
      end

      assign idle_to = !o_stb_q && (idle_q == '1);
    end else begin : g_noidle
      assign idle_to = 1'b0;
    end
  endgenerate

  // Event edge detection, sticky flags and holdoff timer.
  always_comb begin
    last_int_d = i_int;
    last_err_d = i_fifo_err;
    last_aux_d = i_aux;
    pend_d     = (i_int & ~last_int_q) | pend_eff;
    err_flag_d = (i_fifo_err && !last_err_q) || err_eff;
    cts_flag_d = !i_cts || cts_eff;
    aux_flag_d = (i_aux != last_aux_q) || aux_eff;
    holdoff_d  = holdoff_q;
    if (acc_err || acc_int)
      holdoff_d = '1;
    else if (holdoff_q != '0)
      holdoff_d = holdoff_q - LGHOLDOFF'(1);
  end

  // Output slot: data first, then status words by priority.
  always_comb begin
    logic       sel;
    logic [2:0] code;
    o_stb_d  = o_stb_q;
    o_word_d = o_word_q;
    o_last_d = o_last_q;
    spec_d   = spec_q;
    sel      = 1'b1;
    code     = C_IDLE;
    if (err_eff && hold_clr)
      code = C_ERR;
    else if ((|pend_eff) && hold_clr)
      code = C_INT;
    else if (cts_eff)
      code = C_CTS;
    else if (aux_eff || idle_to)
      code = C_IDLE;
    else
      sel = 1'b0;
    if (load) begin
      if (i_stb) begin
        o_stb_d  = 1'b1;
        o_word_d = i_word;
        o_last_d = i_last;
        spec_d   = 1'b0;
        if (i_word[DW-1:DW-2] == 2'b11)
          o_word_d[DW-3:DW-4] = i_aux;
      end else if (sel) begin
        o_stb_d             = 1'b1;
        o_word_d            = '0;
        o_word_d[DW-1:DW-2] = 2'b11;
        o_word_d[DW-3:DW-4] = i_aux;
        o_word_d[DW-5:DW-7] = code;
        o_word_d[NINT-1:0]  = pend_eff;
        o_last_d            = 1'b1;
        spec_d              = 1'b1;
      end else begin
        o_stb_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stb_q    <= 1'b0;
      o_word_q   <= '0;
      o_last_q   <= 1'b0;
      spec_q     <= 1'b0;
      pend_q     <= '0;
      last_int_q <= '0;
      last_err_q <= 1'b0;
      last_aux_q <= '0;
      err_flag_q <= 1'b0;
      cts_flag_q <= 1'b0;
      aux_flag_q <= 1'b0;
      holdoff_q  <= '0;
    end else begin
      o_stb_q    <= o_stb_d;
      o_word_q   <= o_word_d;
      o_last_q   <= o_last_d;
      spec_q     <= spec_d;
      pend_q     <= pend_d;
      last_int_q <= last_int_d;
      last_err_q <= last_err_d;
      last_aux_q <= last_aux_d;
      err_flag_q <= err_flag_d;
      cts_flag_q <= cts_flag_d;
      aux_flag_q <= aux_flag_d;
      holdoff_q  <= holdoff_d;
    end
  end

  assign o_stb     = o_stb_q;
  assign o_word    = o_word_q;
  assign o_last    = o_last_q;
  assign o_busy    = o_stb_q && i_busy;
  assign o_pending = pend_q;
  assign o_holdoff = (holdoff_q != '0);

endmodule

// File: doc/exidle_mc.md
Name: exidle_mc

Overview:
- Multi-channel, parametrised successor to the exbus idle/status inserter.
- Sits between the exbus word source and the exbus compressor/serialiser.
- Passes data words through unchanged, except that special words are stamped with the AUX field.
- In gaps between data words it inserts special status words for: FIFO errors, per-channel interrupt events, CTS drops, AUX changes and idle keep-alives.
- FIFO-error and interrupt reports are rate-limited by a holdoff timer.

Parameters:
- DW, 35: word width. Bits [DW-1:DW-2]==2'b11 mark a special word. Requires DW >= 7+NINT.
- NAUX, 2: AUX field width. Fixed at 2 in this generation; carried at [DW-3:DW-4].
- NINT, 4: number of independent interrupt inputs.
- OPT_IDLE, 1: when 1, generate idle keep-alive words on timeout.
- LGIDLE, 23: idle timeout is 2^LGIDLE-1 cycles. Benches use 4.
- LGHOLDOFF, 16: holdoff after a FIFO-error or interrupt report is 2^LGHOLDOFF-1 cycles. Benches use 3.

Ports:
- i_clk, input, 1: clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_stb, input, 1: data word valid.
- i_word, input, DW: data word.
- i_last, input, 1: last word of a packet.
- o_busy, output, 1: upstream stall, equal to o_stb && i_busy.
- i_aux, input, NAUX: AUX status, sampled every cycle.
- i_cts, input, 1: clear-to-send. Low means dropped.
- i_int, input, NINT: interrupt lines. Rising edges are reported.
- i_fifo_err, input, 1: FIFO error. Rising edge is reported.
- o_stb, output, 1: output word valid.
- o_word, output, DW: output word.
- o_last, output, 1: packet end.
- o_pending, output, NINT: interrupt pending vector.
- o_holdoff, output, 1: holdoff timer running.
- i_busy, input, 1: downstream stall.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): all of the following clear to 0 immediately:
  - o_stb, o_word, o_last.
  - Pending flags, the edge-detect registers (last_int, last_err) and the aux, cts and err flags.
  - The holdoff and idle counters.
- Accept: the output is accepted when o_stb && !i_busy. While o_stb && i_busy, o_stb, o_word and o_last hold stable.
- Load slot: a new word loads when !o_stb || !i_busy. Priority within a slot:
  1. Data: i_stb. Registered with 1-cycle latency, o_last = i_last. If i_word[DW-1:DW-2]==2'b11, bits [DW-3:DW-4] are replaced with the current i_aux.
  2. FIFO error: err_flag && holdoff==0. Code 3'b011.
  3. Interrupt: |pend && holdoff==0. Code 3'b001.
  4. CTS drop: cts_flag. Code 3'b010.
  5. Idle: aux_flag, or (OPT_IDLE && idle timeout). Code 3'b000.
  6. If nothing qualifies, o_stb drops after an accept.
- Special word layout:
  - [DW-1:DW-2] = 2'b11.
  - [DW-3:DW-4] = i_aux.
  - [DW-5:DW-7] = code.
  - [NINT-1:0] = pend snapshot at load.
  - All other bits 0.
  - o_last = 1.
- Flags:
  - err_flag: set on i_fifo_err rising edge; cleared on accept of a code-011 word.
  - pend[k]: set on i_int[k] rising edge; cleared on accept of a code-001 word whose bit k is 1. If set and clear coincide, set wins.
  - cts_flag: set while !i_cts; cleared on accept of a code-010 word if i_cts is high that cycle.
  - aux_flag: set when i_aux differs from the previous cycle; cleared on accept of any special word.
  - All flags are edge-detected against registered previous values.
- Holdoff: loaded with all-ones on accept of a code-011 or code-001 word, then decrements to 0 and stops. o_holdoff = (holdoff != 0). Holdoff inhibits only codes 011 and 001.
- Idle counter: cleared whenever o_stb is high. Otherwise increments, saturating at 2^LGIDLE-1, which is the timeout. With OPT_IDLE=0 the counter is absent and only aux_flag triggers idle words.
- Data never waits behind a special word that has not yet been loaded. A loaded special word completes before the next data word.
- o_pending = pend.

Test Plan (DW=35, NINT=4, LGIDLE=4, LGHOLDOFF=3):
- Data pass-through:
  - Stimulus: i_stb with 35'h1_2345_6789, i_last=1, i_busy=0.
  - Response: next cycle o_stb=1, o_word=35'h1_2345_6789, o_last=1. o_busy never asserts.
- Backpressure:
  - Stimulus: i_busy=1 for 5 cycles with a word loaded.
  - Response: o_word stable and o_busy=1 throughout. A queued i_stb is accepted exactly 1 cycle after i_busy falls.
- Interrupts and holdoff:
  - Stimulus: pulse i_int[2]; 2 cycles later pulse i_int[0].
  - Response:
    - First special word has code 001 with low nibble 4'b0100.
    - o_holdoff then stays high 7 cycles.
    - Next special word has code 001 with low nibble 4'b0001, loaded on the first cycle holdoff==0.
- Priority:
  - Stimulus: i_fifo_err rise, i_int[1] rise and i_stb in the same cycle.
  - Response, in order:
    - Data word first.
    - Then a code-011 word with pend=4'b0010.
    - After 7 holdoff cycles, a code-001 word.
- Idle:
  - Stimulus: no activity for 15 cycles.
  - Response: a code-000 word with AUX=i_aux. Idle words repeat every 15 idle cycles after each accept.
  - Stimulus: toggle i_aux to 2'b10.
  - Response: an immediate idle word with [32:31]=2'b10.
- Reset:
  - Stimulus: assert i_reset mid-stall, with pend=4'b1111 and holdoff running.
  - Response: o_stb, o_pending and o_holdoff go 0 with no clock edge. No pending reports survive reset.
